alu_exec: RTL and testbench
===========================

// Module: alu_exec
// PURPOSE
//  Execute stage downstream of the 8x32 register file. Takes the two read-port
//  operands (q0 -> opa, q1 -> opb) plus op/destination from issue logic. Computes
//  the ALU result and drives the RF write port (we/write_reg/data_in) one
//  writeback per instruction. Also maintains NZCV flags. MUL is iterative
//  (shift-add, one bit per cycle).
// PARAMETERS
//  DATA_W   32  operand/result width
//  REG_AW   3   register address width (8 registers)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous reset, active-high
//  issue_valid  in   1       op/rd/opa/opb valid this cycle
//  issue_ready  out  1       stage can accept; transfer = issue_valid & issue_ready
//  op           in   3       000 ADD,001 SUB,010 AND,011 ORR,100 EOR,101 LSL,110 LSR,111 MUL
//  rd           in   REG_AW  destination register
//  opa          in   DATA_W  operand A (RF q0)
//  opb          in   DATA_W  operand B (RF q1); shifts use opb[$clog2(DATA_W)-1:0]
//  wb_we        out  1       RF write enable (to rf.we)
//  wb_reg       out  REG_AW  RF write address (to rf.write_reg)
//  wb_data      out  DATA_W  RF write data (to rf.data_in)
//  flags        out  4       {N,Z,C,V}
//  busy         out  1       high while in MUL state
//  ill_op       out  1       one-cycle pulse on accepted illegal op (see CONFIGURATION)
// BEHAVIOUR
//  - Single clock clk; synchronous active-high rst. Reset: state=IDLE, wb_we=0,
//    wb_reg=0, wb_data=0, flags=4'b0000, busy=0, ill_op=0, mul counter=0.
//  - FSM states:
//    - IDLE: issue_ready=1.
//    - WB: wb_we=1 for exactly this cycle; issue_ready=1.
//    - MUL: issue_ready=0, busy=1.
//  - Accepting a non-MUL op in IDLE or WB -> next state WB; result registered.
//    Latency 1: accept at edge T, wb_we high in cycle T+1.
//    Back-to-back issue gives one writeback per cycle.
//  - Accepting MUL in IDLE or WB -> MUL.
//    - Latch opa/opb/rd; acc=0; counter=DATA_W-1.
//    - Each cycle: if mcand-LSB then acc+=mplier; shift; decrement.
//    - At counter==0 -> WB. Accept at T, wb_we high in cycle T+DATA_W+1
//      (cycle T+33 for DATA_W=32).
//    - Result = low DATA_W bits of the product.
//  - No accept in WB -> IDLE.
//  - issue_valid while issue_ready=0 is ignored. The upstream stage holds its
//    inputs until accepted.
//  - Arithmetic is modulo 2^DATA_W.
//    - SUB = opa-opb; C = NOT borrow (1 when opa>=opb unsigned).
//    - V = signed overflow for ADD/SUB.
//  - Flag update at the writeback cycle edge:
//    - ADD/SUB update N,Z,C,V.
//    - AND/ORR/EOR/MUL update N,Z only; C,V hold.
//    - LSL/LSR update N,Z. C = last bit shifted out when shamt!=0; C holds when
//      shamt==0.
//  - Z=1 iff result==0. N=result[DATA_W-1].
//  - rst while in MUL: abandon the operation, no writeback, return to IDLE next
//    cycle. rst has priority over a simultaneous accept.
//  - wb_reg/wb_data hold their last value while wb_we=0.
// CONFIGURATION
//  ALU_MUL_EN defined: op 111 is the iterative MUL as above; ill_op stays 0.
//  ALU_MUL_EN undefined: no MUL state or multiplier logic. On accepting op 111:
//    - next state IDLE; wb_we stays 0; flags hold.
//    - ill_op pulses high in cycle T+1.
//    - busy is tied 0.
// TESTING
//  1. rst high 2 cycles -> wb_we=0, flags=0000, issue_ready=1.
//  2. ADD opa=FFFFFFFE opb=00000002 rd=1 -> next cycle wb_we=1, wb_reg=1,
//     wb_data=0, flags N0 Z1 C1 V0.
//  3. Back-to-back SUB 0000FFFF-FFFF0000 rd=2, then AND FFFF0000&0000FFFF rd=3 ->
//     wb 0001FFFF (C0), then wb 0 (Z1); wb_we high 2 consecutive cycles.
//  4. LSL opa=80000001 opb=1 -> 00000002, C=1; then LSR opa=5 opb=0 -> 5, C held.
//  5. MUL (ALU_MUL_EN) 0000FFFF*00010001 rd=4 -> issue_ready low 32 cycles;
//     wb_data=FFFFFFFF in cycle T+33; flags N1 Z0.
//  6. MUL accepted, rst pulsed at cycle T+10 -> no wb_we ever; IDLE after reset.
//     Without ALU_MUL_EN: op 111 -> ill_op pulse, no wb_we.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: execute stage sitting behind the 8x32 register file.
// Computes ADD/SUB/AND/ORR/EOR/LSL/LSR in one cycle, keeps NZCV flags and
// drives the register file write port with one writeback per instruction.
// Build option: define ALU_MUL_EN to enable op 111 as an iterative shift-add
// multiplier; without it, op 111 is rejected with a one-cycle o_ill_op pulse.
module alu_exec #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_issue_valid,
   output logic              o_issue_ready,
   input  logic [2:0]        i_op,
   input  logic [REG_AW-1:0] i_rd,
   input  logic [DATA_W-1:0] i_opa,
   input  logic [DATA_W-1:0] i_opb,
   output logic              o_wb_we,
   output logic [REG_AW-1:0] o_wb_reg,
   output logic [DATA_W-1:0] o_wb_data,
   output logic [3:0]        o_flags,
   output logic              o_busy,
   output logic              o_ill_op
);

   localparam int SH_W = $clog2(DATA_W);
   localparam int MSB  = DATA_W - 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_ORR = 3'b011;
   localparam logic [2:0] OP_EOR = 3'b100;
   localparam logic [2:0] OP_LSL = 3'b101;
   localparam logic [2:0] OP_LSR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WB   = 2'd1;
`ifdef ALU_MUL_EN
   localparam logic [1:0] S_MUL  = 2'd2;
`endif

   logic [1:0]        r_state;
   logic [REG_AW-1:0] r_wbReg;
   logic [DATA_W-1:0] r_wbData;
   logic [3:0]        r_flags;
   logic              r_illOp;

   logic              w_accept;
   logic [SH_W-1:0]   w_shamt;
   logic [DATA_W:0]   w_sum;
   logic [DATA_W:0]   w_diff;
   logic [DATA_W:0]   w_shl;
   logic [DATA_W:0]   w_shr;
   logic [DATA_W-1:0] w_result;
   logic              w_c;
   logic              w_v;
   logic [3:0]        w_flagsNext;

   assign w_accept = i_issue_valid & o_issue_ready;
   assign w_shamt  = i_opb[SH_W-1:0];
   assign w_sum    = {1'b0, i_opa} + {1'b0, i_opb};
   assign w_diff   = {1'b0, i_opa} - {1'b0, i_opb};
   // The extra bit on each shift catches the last bit pushed out, which becomes C.
   assign w_shl    = {1'b0, i_opa} << w_shamt;
   assign w_shr    = {i_opa, 1'b0} >> w_shamt;

   // Single-cycle result and the flags it would produce; C and V default to holding.
   always_comb begin
      w_result = '0;
      w_c      = r_flags[1];
      w_v      = r_flags[0];
      case (i_op)
         OP_ADD: begin
            w_result = w_sum[MSB:0];
            w_c      = w_sum[DATA_W];
            w_v      = (i_opa[MSB] == i_opb[MSB]) && (w_sum[MSB] != i_opa[MSB]);
         end
         OP_SUB: begin
            w_result = w_diff[MSB:0];
            w_c      = ~w_diff[DATA_W];
            w_v      = (i_opa[MSB] != i_opb[MSB]) && (w_diff[MSB] != i_opa[MSB]);
         end
         OP_AND: w_result = i_opa & i_opb;
         OP_ORR: w_result = i_opa | i_opb;
         OP_EOR: w_result = i_opa ^ i_opb;
         OP_LSL: begin
            w_result = w_shl[MSB:0];
            if (w_shamt != '0) w_c = w_shl[DATA_W];
         end
         OP_LSR: begin
            w_result = w_shr[DATA_W:1];
            if (w_shamt != '0) w_c = w_shr[0];
         end
         default: w_result = '0;
      endcase
   end

   assign w_flagsNext = {w_result[MSB], (w_result == '0), w_c, w_v};

`ifdef ALU_MUL_EN
   logic [DATA_W-1:0] r_mcand;
   logic [DATA_W-1:0] r_mplier;
   logic [DATA_W-1:0] r_acc;
   logic [SH_W-1:0]   r_mulCnt;
   logic [REG_AW-1:0] r_mulRd;
   logic [DATA_W-1:0] w_accNext;
   logic              w_mulDone;

   assign w_accNext = r_mcand[0] ? (r_acc + r_mplier) : r_acc;
   assign w_mulDone = (r_state == S_MUL) && (r_mulCnt == '0);

   // Shift-add multiplier: one multiplicand bit consumed per cycle while in MUL.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_mulCnt <= '0;
         r_mulRd  <= '0;
      end else if (w_accept && i_op == OP_MUL) begin
         r_mcand  <= i_opa;
         r_mplier <= i_opb;
         r_acc    <= '0;
         r_mulCnt <= SH_W'(DATA_W - 1);
         r_mulRd  <= i_rd;
      end else if (r_state == S_MUL) begin
         r_acc    <= w_accNext;
         r_mcand  <= r_mcand >> 1;
         r_mplier <= r_mplier << 1;
         if (r_mulCnt != '0) r_mulCnt <= r_mulCnt - 1'b1;
      end
   end
`endif

   // Control FSM plus the writeback and flag registers it loads.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_wbReg  <= '0;
         r_wbData <= '0;
         r_flags  <= 4'b0000;
         r_illOp  <= 1'b0;
      end else begin
         r_illOp <= 1'b0;
         case (r_state)
`ifdef ALU_MUL_EN
            S_MUL: begin
               if (w_mulDone) begin
                  r_state  <= S_WB;
                  r_wbReg  <= r_mulRd;
                  r_wbData <= w_accNext;
                  r_flags  <= {w_accNext[MSB], (w_accNext == '0), r_flags[1:0]};
               end
            end
`endif
            default: begin
               if (w_accept && i_op == OP_MUL) begin
`ifdef ALU_MUL_EN
                  r_state <= S_MUL;
`else
                  r_state <= S_IDLE;
                  r_illOp <= 1'b1;
`endif
               end else if (w_accept) begin
                  r_state  <= S_WB;
                  r_wbReg  <= i_rd;
                  r_wbData <= w_result;
                  r_flags  <= w_flagsNext;
               end else begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

`ifdef ALU_MUL_EN
   assign o_issue_ready = (r_state != S_MUL);
   assign o_busy        = (r_state == S_MUL);
`else
   assign o_issue_ready = 1'b1;
   assign o_busy        = 1'b0;
`endif
   assign o_wb_we   = (r_state == S_WB);
   assign o_wb_reg  = r_wbReg;
   assign o_wb_data = r_wbData;
   assign o_flags   = r_flags;
   assign o_ill_op  = r_illOp;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: self-checking bench for alu_exec. Directed vector table for the
// single-cycle ops, hand sequences for reset/multiply corners, and random
// stimulus compared against an arithmetic reference model.
module tb_alu_exec;

   localparam int DW = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [2:0]  op = '0;
   logic [2:0]  rd = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        ready;
   logic        wbWe;
   logic [2:0]  wbReg;
   logic [31:0] wbData;
   logic [3:0]  flags;
   logic        busy;
   logic        illOp;

   int testsRun = 0;
   int testsFailed = 0;

   logic [3:0]  mFlags = '0;
   logic [31:0] mLastData = '0;
   logic [2:0]  mLastReg = '0;

   typedef struct {
      logic [2:0]  op;
      logic [2:0]  rd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expData;
      logic [3:0]  expFlags;
   } vec_t;

   vec_t vecs[11];

   alu_exec #(.DATA_W(DW), .REG_AW(3)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_issue_valid(valid),
      .o_issue_ready(ready),
      .i_op(op),
      .i_rd(rd),
      .i_opa(a),
      .i_opb(b),
      .o_wb_we(wbWe),
      .o_wb_reg(wbReg),
      .o_wb_data(wbData),
      .o_flags(flags),
      .o_busy(busy),
      .o_ill_op(illOp)
   );

   // Free-running 10ns clock
   always #5 clk = ~clk;

   // Reference model: plain wide arithmetic on the operation's definition.
   function automatic void refModel(input logic [2:0] fOp, input logic [31:0] fa,
                                    input logic [31:0] fb, input logic [3:0] fin,
                                    output logic [31:0] res, output logic [3:0] fout);
      longint unsigned ua;
      longint unsigned ub;
      longint sa;
      longint sb;
      longint wide;
      int sh;
      logic c;
      logic v;
      ua = fa;
      ub = fb;
      sa = longint'($signed(fa));
      sb = longint'($signed(fb));
      sh = int'(fb[4:0]);
      c = fin[1];
      v = fin[0];
      res = '0;
      case (fOp)
         3'd0: begin
            res = fa + fb;
            c = (ua + ub) > 64'hFFFF_FFFF;
            wide = sa + sb;
            v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         3'd1: begin
            res = fa - fb;
            c = (ua >= ub);
            wide = sa - sb;
            v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         3'd2: res = fa & fb;
         3'd3: res = fa | fb;
         3'd4: res = fa ^ fb;
         3'd5: begin
            res = fa << sh;
            if (sh != 0) c = ((ua >> (32 - sh)) & 64'd1) != 0;
         end
         3'd6: begin
            res = fa >> sh;
            if (sh != 0) c = ((ua >> (sh - 1)) & 64'd1) != 0;
         end
         default: res = 32'((ua * ub) & 64'hFFFF_FFFF);
      endcase
      fout = {res[31], (res == 32'd0), c, v};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, wait (bounded) for its writeback and compare against the model.
   task automatic applyStimulus(input logic [2:0] iOp, input logic [2:0] iRd,
                                input logic [31:0] iA, input logic [31:0] iB);
      logic [31:0] expData;
      logic [3:0]  expFlags;
      int cycles;
      int expCycles;
      bit isIll;
      refModel(iOp, iA, iB, mFlags, expData, expFlags);
`ifdef ALU_MUL_EN
      isIll = 1'b0;
`else
      isIll = (iOp == 3'b111);
`endif
      expCycles = (iOp == 3'b111 && !isIll) ? DW : 0;
      op = iOp;
      rd = iRd;
      a = iA;
      b = iB;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      cycles = 0;
      while (!ready && cycles < 200) begin
         checkOutput("busyWhileMul", 32'(busy), 32'd1);
         tick();
         cycles++;
      end
      checkOutput("latency", 32'(cycles), 32'(expCycles));
      if (isIll) begin
         checkOutput("illPulse", 32'(illOp), 32'd1);
         checkOutput("illNoWe", 32'(wbWe), 32'd0);
         checkOutput("illFlagsHold", 32'(flags), 32'(mFlags));
         tick();
         checkOutput("illPulseEnds", 32'(illOp), 32'd0);
      end else begin
         checkOutput("wbWe", 32'(wbWe), 32'd1);
         checkOutput("wbReg", 32'(wbReg), 32'(iRd));
         checkOutput("wbData", wbData, expData);
         checkOutput("flags", 32'(flags), 32'(expFlags));
         mFlags = expFlags;
         mLastData = expData;
         mLastReg = iRd;
      end
      checkOutput("busyDone", 32'(busy), 32'd0);
   endtask

   // One idle cycle: no writeback, port values hold.
   task automatic idleCheck();
      tick();
      checkOutput("idleWe", 32'(wbWe), 32'd0);
      checkOutput("idleDataHold", wbData, mLastData);
      checkOutput("idleRegHold", 32'(wbReg), 32'(mLastReg));
      checkOutput("idleReady", 32'(ready), 32'd1);
   endtask

   initial begin
      int seen;
      logic [2:0] rop;
      logic [31:0] ra;
      logic [31:0] rb;

      vecs[0]  = '{3'd0, 3'd1, 32'hFFFF_FFFE, 32'h0000_0002, 32'h0000_0000, 4'b0110};
      vecs[1]  = '{3'd1, 3'd2, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0001_FFFF, 4'b0000};
      vecs[2]  = '{3'd2, 3'd3, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 4'b0100};
      vecs[3]  = '{3'd5, 3'd5, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 4'b0010};
      vecs[4]  = '{3'd6, 3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 4'b0010};
      vecs[5]  = '{3'd0, 3'd7, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001};
      vecs[6]  = '{3'd3, 3'd0, 32'h0F0F_0000, 32'hF000_0000, 32'hFF0F_0000, 4'b1001};
      vecs[7]  = '{3'd1, 3'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011};
      vecs[8]  = '{3'd4, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0111};
      vecs[9]  = '{3'd6, 3'd3, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 4'b0001};
      vecs[10] = '{3'd5, 3'd4, 32'h0000_0003, 32'h0000_0020, 32'h0000_0003, 4'b0001};

      // Reset held for two cycles
      rst = 1'b1;
      tick();
      tick();
      checkOutput("rstWe", 32'(wbWe), 32'd0);
      checkOutput("rstFlags", 32'(flags), 32'd0);
      checkOutput("rstReady", 32'(ready), 32'd1);
      checkOutput("rstData", wbData, 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstIll", 32'(illOp), 32'd0);
      rst = 1'b0;

      // Directed vectors issued back-to-back: one writeback per cycle
      for (int i = 0; i < 11; i++) begin
         op = vecs[i].op;
         rd = vecs[i].rd;
         a = vecs[i].a;
         b = vecs[i].b;
         valid = 1'b1;
         tick();
         checkOutput($sformatf("vec%0d_we", i), 32'(wbWe), 32'd1);
         checkOutput($sformatf("vec%0d_reg", i), 32'(wbReg), 32'(vecs[i].rd));
         checkOutput($sformatf("vec%0d_data", i), wbData, vecs[i].expData);
         checkOutput($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].expFlags));
      end
      valid = 1'b0;
      mFlags = vecs[10].expFlags;
      mLastData = vecs[10].expData;
      mLastReg = vecs[10].rd;
      idleCheck();

      // Multiply (or illegal op when the multiplier is not built)
      applyStimulus(3'b111, 3'd4, 32'h0000_FFFF, 32'h0001_0001);
      idleCheck();

`ifdef ALU_MUL_EN
      // Reset part-way through a multiply abandons it with no writeback
      op = 3'b111;
      rd = 3'd5;
      a = 32'h1234_5678;
      b = 32'h0000_0003;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      repeat (9) tick();
      checkOutput("abortBusyBefore", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("abortReady", 32'(ready), 32'd1);
      checkOutput("abortBusy", 32'(busy), 32'd0);
      checkOutput("abortFlags", 32'(flags), 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (wbWe) seen++;
         tick();
      end
      checkOutput("abortNoWb", 32'(seen), 32'd0);
`endif

      // Reset has priority over a simultaneous accept
      rst = 1'b1;
      op = 3'd0;
      rd = 3'd6;
      a = 32'h0000_0011;
      b = 32'h0000_0022;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      checkOutput("rstAcceptWe", 32'(wbWe), 32'd0);
      checkOutput("rstAcceptData", wbData, 32'd0);
      tick();
      rst = 1'b0;
      mFlags = '0;
      mLastData = '0;
      mLastReg = '0;

      // Random ops with occasional idle gaps
      for (int i = 0; i < 200; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'($urandom_range(0, 40));
            1: ra = 32'h8000_0000;
            2: ra = 32'h7FFF_FFFF;
            3: rb = ra;
            default: ;
         endcase
         applyStimulus(rop, 3'($urandom_range(0, 7)), ra, rb);
         if ($urandom_range(0, 1) == 1) idleCheck();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
